// File: rtl/cast_inject_arbiter.sv
// Packet-granular round-robin arbiter feeding one cast_network router local port.
// Optional per-requester packet counters are enabled by defining CAST_INJ_STAT_EN.
module cast_inject_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 64,
  parameter int unsigned PW   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                noc_valid,
  output logic [DW-1:0]       noc_data,
  input  logic                noc_ready,
  output logic                busy,
  output logic [PW-1:0]       owner,
  output logic                proto_err
`ifdef CAST_INJ_STAT_EN
  ,
  output logic [NREQ*16-1:0]  pkt_cnt
`endif
);

  localparam logic [1:0] TypeHead   = 2'b01;
  localparam logic [1:0] TypeTail   = 2'b10;
  localparam logic [1:0] TypeSingle = 2'b11;

  typedef enum logic {StIdle, StLock} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic            proto_err_q, proto_err_d;
  logic            noc_valid_q, noc_valid_d;
  logic [DW-1:0]   noc_data_q, noc_data_d;

  logic            can_take, push, found;
  logic [PW-1:0]   sel, idx;
  int unsigned     s;
  logic [DW-1:0]   sel_data;
  logic [1:0]      sel_type;
  logic [NREQ-1:0] eligible, stray;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (32'(p) == NREQ - 1) ? '0 : p + PW'(1);
  endfunction

  // Head/single carry type bit 0; body/tail do not and may only arrive under a lock.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && req_data[i*DW + DW - 2];
      stray[i]    = req_valid[i] && !req_data[i*DW + DW - 2];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    proto_err_d = proto_err_q;
    noc_valid_d = noc_valid_q;
    noc_data_d  = noc_data_q;
    req_ready   = '0;
    found       = 1'b0;
    sel         = owner_q;
    idx         = '0;
    s           = 0;
    sel_data    = '0;
    can_take    = !noc_valid_q || noc_ready;

    if (state_q == StIdle) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        s = 32'(rr_ptr_q) + k;
        if (s >= NREQ) s = s - NREQ;
        idx = PW'(s);
        if (!found && eligible[idx]) begin
          found = 1'b1;
          sel   = idx;
        end
      end
    end

    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel == PW'(i)) sel_data = req_data[i*DW +: DW];
    end
    sel_type = sel_data[DW-1:DW-2];

    if (state_q == StIdle) begin
      if (found) req_ready[sel] = can_take;
      if (|stray) proto_err_d = 1'b1;
    end else begin
      req_ready[sel] = can_take;
      // A fresh head from the owner is still forwarded; only the flag records it.
      if (req_valid[sel] && (sel_type == TypeHead || sel_type == TypeSingle)) begin
        proto_err_d = 1'b1;
      end
    end

    push = |(req_valid & req_ready);

    if (push) begin
      if (state_q == StIdle) begin
        owner_d = sel;
        if (sel_type == TypeSingle) rr_ptr_d = wrap_inc(sel);
        else                        state_d  = StLock;
      end else if (sel_type == TypeTail) begin
        state_d  = StIdle;
        rr_ptr_d = wrap_inc(owner_q);
      end
      noc_valid_d = 1'b1;
      noc_data_d  = sel_data;
    end else if (noc_ready) begin
      noc_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      proto_err_q <= 1'b0;
      noc_valid_q <= 1'b0;
      noc_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      proto_err_q <= proto_err_d;
      noc_valid_q <= noc_valid_d;
      noc_data_q  <= noc_data_d;
    end
  end

  assign noc_valid = noc_valid_q;
  assign noc_data  = noc_data_q;
  assign busy      = (state_q == StLock);
  assign owner     = owner_q;
  assign proto_err = proto_err_q;

`ifdef CAST_INJ_STAT_EN
  // Tail and single both carry type bit 1: each marks the end of a packet.
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    logic [15:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (req_valid[i] && req_ready[i] && req_data[i*DW + DW - 1]) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign pkt_cnt[i*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_cast_inject_arbiter.sv
// Directed self-checking bench for cast_inject_arbiter (NREQ=4, DW=64).
module tb_cast_inject_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 64;
  localparam int unsigned PW   = 2;

  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] T = 2'b10;
  localparam logic [1:0] S = 2'b11;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                noc_valid;
  logic [DW-1:0]       noc_data;
  logic                noc_ready;
  logic                busy;
  logic [PW-1:0]       owner;
  logic                proto_err;
`ifdef CAST_INJ_STAT_EN
  logic [NREQ*16-1:0]  pkt_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  cast_inject_arbiter #(
    .NREQ (NREQ),
    .DW   (DW),
    .PW   (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .noc_valid (noc_valid),
    .noc_data  (noc_data),
    .noc_ready (noc_ready),
    .busy      (busy),
    .owner     (owner),
    .proto_err (proto_err)
`ifdef CAST_INJ_STAT_EN
    ,
    .pkt_cnt   (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fl(input logic [1:0] t, input logic [7:0] id);
    return {t, 54'd0, id};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(input int i, input logic [63:0] f);
    req_data[i*DW +: DW] = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    noc_ready = 1'b1;
    repeat (2) tick();
    check("rst_noc_valid", 64'(noc_valid), 64'(0));
    check("rst_noc_data", noc_data, 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_owner", 64'(owner), 64'(0));
    check("rst_proto_err", 64'(proto_err), 64'(0));
    rst = 1'b0;
    tick();
    check("idle_ready", 64'(req_ready), 64'(0));

    // Three back-to-back singles from req0.
    req_valid = 4'b0001;
    put(0, fl(S, 8'h10));
    #1 check("s1_ready", 64'(req_ready), 64'b0001);
    tick();
    check("s1_valid", 64'(noc_valid), 64'(1));
    check("s1_data", noc_data, fl(S, 8'h10));
    put(0, fl(S, 8'h11));
    tick();
    check("s2_valid", 64'(noc_valid), 64'(1));
    check("s2_data", noc_data, fl(S, 8'h11));
    put(0, fl(S, 8'h12));
    tick();
    check("s3_valid", 64'(noc_valid), 64'(1));
    check("s3_data", noc_data, fl(S, 8'h12));
    check("s3_busy", 64'(busy), 64'(0));
    req_valid = '0;
    tick();
    check("s_drain", 64'(noc_valid), 64'(0));

    // rr_ptr is 1: req1 beats req0, then req3 beats req0 from pointer 2.
    req_valid = 4'b0011;
    put(0, fl(S, 8'h20));
    put(1, fl(S, 8'h21));
    #1 check("rr1_ready", 64'(req_ready), 64'b0010);
    tick();
    check("rr1_data", noc_data, fl(S, 8'h21));
    check("rr1_owner", 64'(owner), 64'(1));
    req_valid = 4'b1001;
    put(3, fl(S, 8'h23));
    #1 check("rr2_ready", 64'(req_ready), 64'b1000);
    tick();
    check("rr2_data", noc_data, fl(S, 8'h23));
    check("rr2_owner", 64'(owner), 64'(3));
    req_valid = '0;
    tick();

    // Contention: req1 and req2 both offer 4-flit packets, rr_ptr is 0.
    req_valid = 4'b0110;
    put(1, fl(H, 8'h31));
    put(2, fl(H, 8'h41));
    #1 check("c_ready0", 64'(req_ready), 64'b0010);
    tick();
    check("c_d0", noc_data, fl(H, 8'h31));
    check("c_busy", 64'(busy), 64'(1));
    check("c_owner1", 64'(owner), 64'(1));
    put(1, fl(B, 8'h32));
    #1 check("c_ready1", 64'(req_ready), 64'b0010);
    tick();
    check("c_d1", noc_data, fl(B, 8'h32));
    put(1, fl(B, 8'h33));
    #1 check("c_ready2", 64'(req_ready), 64'b0010);
    tick();
    check("c_d2", noc_data, fl(B, 8'h33));
    put(1, fl(T, 8'h34));
    #1 check("c_ready3", 64'(req_ready), 64'b0010);
    tick();
    check("c_d3", noc_data, fl(T, 8'h34));
    check("c_unlock", 64'(busy), 64'(0));
    req_valid = 4'b0100;
    #1 check("c_ready4", 64'(req_ready), 64'b0100);
    tick();
    check("c_d4", noc_data, fl(H, 8'h41));
    check("c_owner2", 64'(owner), 64'(2));
    put(2, fl(B, 8'h42));
    tick();
    check("c_d5", noc_data, fl(B, 8'h42));
    put(2, fl(B, 8'h43));
    tick();
    check("c_d6", noc_data, fl(B, 8'h43));
    put(2, fl(T, 8'h44));
    tick();
    check("c_d7", noc_data, fl(T, 8'h44));
    check("c_end_busy", 64'(busy), 64'(0));
    check("c_end_owner", 64'(owner), 64'(2));
    req_valid = '0;
    tick();

    // Backpressure mid-packet on req0 (rr_ptr 3 wraps to req0).
    req_valid = 4'b0001;
    put(0, fl(H, 8'h51));
    #1 check("bp_ready0", 64'(req_ready), 64'b0001);
    tick();
    check("bp_d0", noc_data, fl(H, 8'h51));
    put(0, fl(B, 8'h52));
    noc_ready = 1'b0;
    #1 check("bp_stall", 64'(req_ready), 64'b0000);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_data", noc_data, fl(H, 8'h51));
      check("bp_hold_valid", 64'(noc_valid), 64'(1));
      check("bp_hold_ready", 64'(req_ready), 64'b0000);
    end
    noc_ready = 1'b1;
    #1 check("bp_release", 64'(req_ready), 64'b0001);
    tick();
    check("bp_d1", noc_data, fl(B, 8'h52));
    put(0, fl(B, 8'h53));
    tick();
    check("bp_d2", noc_data, fl(B, 8'h53));
    put(0, fl(T, 8'h54));
    tick();
    check("bp_d3", noc_data, fl(T, 8'h54));
    check("bp_unlock", 64'(busy), 64'(0));
    req_valid = '0;
    tick();
    check("bp_drain", 64'(noc_valid), 64'(0));

    // Wrap-around: move rr_ptr to 3, then req3 and req0 contend.
    req_valid = 4'b0100;
    put(2, fl(S, 8'h60));
    #1 check("w_pre_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = 4'b1001;
    put(3, fl(S, 8'h63));
    put(0, fl(S, 8'h64));
    #1 check("w_ready3", 64'(req_ready), 64'b1000);
    tick();
    check("w_d3", noc_data, fl(S, 8'h63));
    req_valid = 4'b0001;
    #1 check("w_ready0", 64'(req_ready), 64'b0001);
    tick();
    check("w_d0", noc_data, fl(S, 8'h64));
    req_valid = 4'b0011;
    put(1, fl(S, 8'h65));
    #1 check("w_ptr_is_1", 64'(req_ready), 64'b0010);
    req_valid = '0;
    tick();

    // Body flit in IDLE is refused and flagged.
    req_valid = 4'b0100;
    put(2, fl(B, 8'h70));
    #1 check("pe_ready", 64'(req_ready), 64'b0000);
    check("pe_not_yet", 64'(proto_err), 64'(0));
    tick();
    check("pe_set", 64'(proto_err), 64'(1));
    check("pe_no_fwd", 64'(noc_valid), 64'(0));
    req_valid = '0;
    tick();
    check("pe_sticky", 64'(proto_err), 64'(1));

    // Reset after head + one body of a packet on req0.
    req_valid = 4'b0001;
    put(0, fl(H, 8'h61));
    tick();
    put(0, fl(B, 8'h62));
    tick();
    check("rm_d1", noc_data, fl(B, 8'h62));
    check("rm_busy_pre", 64'(busy), 64'(1));
    put(0, fl(B, 8'h63));
    rst = 1'b1;
    #1;
    check("rm_valid", 64'(noc_valid), 64'(0));
    check("rm_busy", 64'(busy), 64'(0));
    check("rm_proto_err", 64'(proto_err), 64'(0));
    req_valid = '0;
    #2 rst = 1'b0;
    tick();
    req_valid = 4'b1000;
    put(3, fl(S, 8'h71));
    #1 check("rm_ready3", 64'(req_ready), 64'b1000);
    tick();
    check("rm_d3", noc_data, fl(S, 8'h71));
    check("rm_owner", 64'(owner), 64'(3));
    check("rm_idle", 64'(busy), 64'(0));

    // Repeated head from the owner while locked: forwarded, flagged, lock kept.
    req_valid = 4'b0010;
    put(1, fl(H, 8'h81));
    tick();
    check("lh_busy0", 64'(busy), 64'(1));
    check("lh_err0", 64'(proto_err), 64'(0));
    put(1, fl(H, 8'h82));
    #1 check("lh_ready", 64'(req_ready), 64'b0010);
    tick();
    check("lh_data", noc_data, fl(H, 8'h82));
    check("lh_busy1", 64'(busy), 64'(1));
    check("lh_err1", 64'(proto_err), 64'(1));
    put(1, fl(T, 8'h83));
    tick();
    check("lh_tail", noc_data, fl(T, 8'h83));
    check("lh_unlock", 64'(busy), 64'(0));
    req_valid = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cast_inject_arbiter.md
Name: cast_inject_arbiter

Overview:
Packet-granular round-robin arbiter that shares one router local input port of cast_network among NREQ injecting sources (drivers or PE channels). Once a head flit wins, the port is locked to that source until its tail flit passes, so multicast packets are never interleaved. A one-entry registered output stage drives the router's data_i/valid_i and obeys its ready_o.

Parameters:
NREQ, 4, number of requesters (2..16)
DW, 64, flit width; bits [DW-1:DW-2] are the flit type
PW, 2, pointer width, equal to clog2(NREQ)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NREQ  per-requester flit valid
req_data  in  NREQ*DW  per-requester flit; requester i occupies bits [i*DW +: DW]
req_ready  out  NREQ  per-requester accept
noc_valid  out  1  to router valid_i
noc_data  out  DW  to router data_i
noc_ready  in  1  from router ready_o
busy  out  1  high while in LOCK
owner  out  PW  current or last granted requester
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Flit type field: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head and tail).
- Reset: state IDLE, rr_ptr=0, owner=0, noc_valid=0, noc_data=0, busy=0, proto_err=0. Reset mid-packet drops the in-flight flit and the lock; no partial packet resumes.
- Output stage: can_take = !noc_valid || noc_ready. A flit accepted at edge k appears on noc_data/noc_valid after edge k (latency 1). A simultaneous pop and push keeps noc_valid=1 and gives full throughput. noc_data holds stable while noc_valid && !noc_ready.
- Transfer on requester i occurs when req_valid[i] && req_ready[i]. At most one req_ready bit is high per cycle.
- IDLE: eligible[i] = req_valid[i] && type in {head, single}. Grant g is the first eligible index at or after rr_ptr, with wrap-around modulo NREQ. req_ready[g]=can_take. On transfer:
  - single: stay IDLE, rr_ptr=g+1 (wrap).
  - head: go to LOCK, owner=g.
- A valid body or tail flit in IDLE is not accepted (req_ready=0) and sets proto_err.
- LOCK: only req_ready[owner]=can_take; all other sources are stalled whatever they present. On transfer of a tail flit: go to IDLE, rr_ptr=owner+1 (wrap). Body flits keep the lock. A head or single flit from the owner in LOCK sets proto_err; it is still forwarded and the lock is retained.
- busy = (state==LOCK). owner updates only on a head or single grant.
- No combinational path from noc_ready to noc_data. req_ready depends combinationally on noc_ready, req_valid and state.

Optional Feature:
Macro CAST_INJ_STAT_EN.
- Defined: adds output pkt_cnt (NREQ*16). Per-requester 16-bit counters increment on each tail or single transfer, wrap at 0xFFFF, and clear on reset.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Single source, single flits: req0 sends 3 singles, noc_ready=1 -> noc_valid high for 3 consecutive cycles starting one cycle after the first accept; rr_ptr ends at 1.
- Contention: req1 and req2 each present a 4-flit packet (head, body, body, tail) in the same cycle, rr_ptr=0 -> all of req1's flits are output contiguously, then req2's; req_ready[2]=0 for 4 cycles; owner=2 at the end.
- Backpressure: noc_ready=0 for 5 cycles during a locked packet -> noc_data stays stable, at most one flit is held, no flit is lost or duplicated, and the order is preserved after release.
- Wrap-around: NREQ=4, rr_ptr=3, req3 and req0 both present singles -> req3 is granted first, then req0; rr_ptr ends at 1.
- Protocol error: a body flit is presented on req2 in IDLE -> req_ready[2]=0, proto_err=1 from the next cycle and stays high until reset.
- Reset mid-packet: assert rst after the head and 1 body flit of a 4-flit packet -> noc_valid=0 and busy=0 immediately (asynchronously); after release, a new single on req3 is granted normally.
